// File: rtl/dcpu16_pkg.sv
// Shared DCPU-16 core constants and the bus arbiter state/grant encodings.
package dcpu16_pkg;

  localparam int DW     = 16;
  localparam int REG_N  = 8;
  localparam int OPC_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FS   = 2'd1,
    ST_AB   = 2'd2
  } arb_st_e;

  typedef enum logic {
    GNT_FS = 1'b0,
    GNT_AB = 1'b1
  } gnt_e;

endpackage

// File: rtl/dcpu16_arb.sv
// Arbitrates the fetch (fs) and operand (ab) toggle-handshake ports of the
// DCPU-16 core onto a single Wishbone master, one bus cycle at a time.
module dcpu16_arb
  import dcpu16_pkg::*;
#(
  parameter int AW = 16,
  parameter int RR = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] fs_adr,
  input  logic          fs_ena,
  output logic          fs_ack,
  output logic [DW-1:0] fs_dti,
  input  logic [AW-1:0] ab_adr,
  input  logic [DW-1:0] ab_dto,
  input  logic          ab_wre,
  input  logic          ab_ena,
  output logic          ab_ack,
  output logic [DW-1:0] ab_dti,
  output logic          wb_cyc,
  output logic          wb_stb,
  output logic          wb_we,
  output logic [AW-1:0] wb_adr,
  output logic [DW-1:0] wb_dto,
  input  logic [DW-1:0] wb_dti,
  input  logic          wb_ack
);

  arb_st_e       st_q, st_d;
  gnt_e          last_q, last_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dto_q, dto_d;
  logic          fs_ack_q, fs_ack_d;
  logic          ab_ack_q, ab_ack_d;
  logic [DW-1:0] fs_dti_q, fs_dti_d;
  logic [DW-1:0] ab_dti_q, ab_dti_d;
  logic          fs_pend, ab_pend, pick_ab;

  // A port has work outstanding while its toggle differs from our ack toggle.
  assign fs_pend = fs_ena ^ fs_ack_q;
  assign ab_pend = ab_ena ^ ab_ack_q;

  always_comb begin
    st_d     = st_q;
    last_d   = last_q;
    cyc_d    = cyc_q;
    we_d     = we_q;
    adr_d    = adr_q;
    dto_d    = dto_q;
    fs_ack_d = fs_ack_q;
    ab_ack_d = ab_ack_q;
    fs_dti_d = fs_dti_q;
    ab_dti_d = ab_dti_q;

    pick_ab = ab_pend;
    if ((RR != 0) && fs_pend && ab_pend) pick_ab = (last_q == GNT_FS);

    unique case (st_q)
      ST_IDLE: begin
        if (fs_pend || ab_pend) begin
          st_d  = pick_ab ? ST_AB : ST_FS;
          cyc_d = 1'b1;
          adr_d = pick_ab ? ab_adr : fs_adr;
          we_d  = pick_ab && ab_wre;
          dto_d = pick_ab ? ab_dto : dto_q;
        end
      end
      ST_FS: begin
        if (wb_ack) begin
          fs_dti_d = wb_dti;
          fs_ack_d = ~fs_ack_q;
          cyc_d    = 1'b0;
          last_d   = GNT_FS;
          st_d     = ST_IDLE;
        end
      end
      ST_AB: begin
        if (wb_ack) begin
          // Writes complete the handshake but leave the read-data register alone.
          if (!we_q) ab_dti_d = wb_dti;
          ab_ack_d = ~ab_ack_q;
          cyc_d    = 1'b0;
          last_d   = GNT_AB;
          st_d     = ST_IDLE;
        end
      end
      default: begin
        cyc_d = 1'b0;
        st_d  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= ST_IDLE;
      last_q   <= GNT_FS;
      cyc_q    <= 1'b0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      dto_q    <= '0;
      fs_ack_q <= 1'b0;
      ab_ack_q <= 1'b0;
      fs_dti_q <= 16'h0;
      ab_dti_q <= 16'h0;
    end else begin
      st_q     <= st_d;
      last_q   <= last_d;
      cyc_q    <= cyc_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      dto_q    <= dto_d;
      fs_ack_q <= fs_ack_d;
      ab_ack_q <= ab_ack_d;
      fs_dti_q <= fs_dti_d;
      ab_dti_q <= ab_dti_d;
    end
  end

  assign wb_cyc = cyc_q;
  assign wb_stb = cyc_q;
  assign wb_we  = we_q;
  assign wb_adr = adr_q;
  assign wb_dto = dto_q;
  assign fs_ack = fs_ack_q;
  assign ab_ack = ab_ack_q;
  assign fs_dti = fs_dti_q;
  assign ab_dti = ab_dti_q;

endmodule

// File: tb/tb_dcpu16_arb.sv
// Bench for dcpu16_arb: instance 0 is fixed-priority, instance 1 round-robin;
// a toggle-level transaction model predicts acks, read data and bus contents.
module tb_dcpu16_arb;

  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0][AW-1:0] fs_adr, ab_adr, wb_adr;
  logic [1:0][15:0]   ab_dto, fs_dti, ab_dti, wb_dto, wb_dti;
  logic [1:0]         fs_ena, fs_ack, ab_ena, ab_ack, ab_wre;
  logic [1:0]         wb_cyc, wb_stb, wb_we, wb_ack;

  // bus slave: acks waits[i]+1 cycles after it first sees the strobe
  logic [1:0]       sl_ack, spur;
  logic [1:0][15:0] seed;
  int               waits[2];
  int               cnt[2];

  for (genvar g = 0; g < 2; g++) begin : gi
    dcpu16_arb #(.AW(AW), .RR(g)) dut (
      .clk(clk), .rst(rst),
      .fs_adr(fs_adr[g]), .fs_ena(fs_ena[g]), .fs_ack(fs_ack[g]), .fs_dti(fs_dti[g]),
      .ab_adr(ab_adr[g]), .ab_dto(ab_dto[g]), .ab_wre(ab_wre[g]), .ab_ena(ab_ena[g]),
      .ab_ack(ab_ack[g]), .ab_dti(ab_dti[g]),
      .wb_cyc(wb_cyc[g]), .wb_stb(wb_stb[g]), .wb_we(wb_we[g]), .wb_adr(wb_adr[g]),
      .wb_dto(wb_dto[g]), .wb_dti(wb_dti[g]), .wb_ack(wb_ack[g])
    );
    assign wb_ack[g] = sl_ack[g] | spur[g];
    assign wb_dti[g] = sl_ack[g] ? (seed[g] ^ wb_adr[g]) : 16'hDEAD;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sl_ack <= '0;
      cnt[0] <= 0;
      cnt[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (wb_cyc[i] && wb_stb[i] && !sl_ack[i]) begin
          if (cnt[i] >= waits[i]) begin
            sl_ack[i] <= 1'b1;
            cnt[i]    <= 0;
          end else cnt[i] <= cnt[i] + 1;
        end else sl_ack[i] <= 1'b0;
      end
    end
  end

  // reference model state, indexed [instance][port], port 0 = fs, 1 = ab
  logic [1:0][1:0]       pend, e_ack;
  logic [1:0][1:0][15:0] e_dti, m_adr;
  logic [1:0]            m_we;
  logic [1:0][15:0]      m_dto;
  int                    t_req[2][2];
  int                    lat[2][2];
  logic [1:0][15:0]      s_adr, s_dto;
  logic [1:0]            s_we, pcyc;
  int                    pulses[2];
  int                    ord[2][8];
  int                    ordn[2];
  int                    ncyc;
  int                    ntests, nfail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ack_of(input int u, input int p);
    return (p != 0) ? ab_ack[u] : fs_ack[u];
  endfunction

  task automatic rst_model();
    for (int u = 0; u < 2; u++) begin
      for (int p = 0; p < 2; p++) begin
        e_ack[u][p] = 1'b0;
        e_dti[u][p] = 16'h0;
        t_req[u][p] = ncyc;
      end
      pend[u][0] = fs_ena[u];
      pend[u][1] = ab_ena[u];
      pcyc[u] = 1'b0;
    end
  endtask

  task automatic issue(input int u, input int p, input logic [15:0] adr,
                       input logic we, input logic [15:0] dto);
    if (p == 0) begin
      fs_adr[u] = adr;
      fs_ena[u] = ~fs_ena[u];
    end else begin
      ab_adr[u] = adr;
      ab_wre[u] = we;
      ab_dto[u] = dto;
      ab_ena[u] = ~ab_ena[u];
      m_we[u]  = we;
      m_dto[u] = dto;
    end
    m_adr[u][p] = adr;
    pend[u][p]  = 1'b1;
    t_req[u][p] = ncyc;
  endtask

  task automatic complete(input int u, input int p);
    logic wr;
    wr = (p != 0) && m_we[u];
    chk("ack_was_pending", pend[u][p], 1'b1);
    chk("bus_adr", s_adr[u], m_adr[u][p]);
    chk("bus_we", s_we[u], wr);
    if (wr) chk("bus_dto", s_dto[u], m_dto[u]);
    if (!wr) e_dti[u][p] = seed[u] ^ m_adr[u][p];
    e_ack[u][p] = ~e_ack[u][p];
    pend[u][p]  = 1'b0;
    lat[u][p]   = ncyc - t_req[u][p];
    if (ordn[u] < 8) ord[u][ordn[u]] = p;
    ordn[u]++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ncyc++;
    for (int u = 0; u < 2; u++) begin
      if (wb_cyc[u] && !pcyc[u]) begin
        s_adr[u] = wb_adr[u];
        s_we[u]  = wb_we[u];
        s_dto[u] = wb_dto[u];
        pulses[u]++;
      end else if (wb_cyc[u]) begin
        chk("bus_hold", {wb_stb[u], wb_we[u], wb_dto[u], wb_adr[u]},
            {1'b1, s_we[u], s_dto[u], s_adr[u]});
      end
      pcyc[u] = wb_cyc[u];
      for (int p = 0; p < 2; p++)
        if (ack_of(u, p) != e_ack[u][p]) complete(u, p);
      chk("fs_dti", fs_dti[u], e_dti[u][0]);
      chk("ab_dti", ab_dti[u], e_dti[u][1]);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (pend != '0 && n < budget) begin
      step();
      n++;
    end
    chk("drain", pend, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev;
    int issued, n, ps0;
    ntests = 0; nfail = 0; ncyc = 0;
    fs_adr = '0; ab_adr = '0; ab_dto = '0; fs_ena = '0; ab_ena = '0; ab_wre = '0;
    spur = '0; seed = '0; waits[0] = 0; waits[1] = 0;
    m_adr = '0; m_we = '0; m_dto = '0; s_adr = '0; s_we = '0; s_dto = '0;
    pulses[0] = 0; pulses[1] = 0; ordn[0] = 0; ordn[1] = 0;
    rst = 1'b0;
    rst_model();
    #12;
    for (int u = 0; u < 2; u++) begin
      chk("rst_cyc", wb_cyc[u], 1'b0);
      chk("rst_stb", wb_stb[u], 1'b0);
      chk("rst_we", wb_we[u], 1'b0);
      chk("rst_adr", wb_adr[u], 16'h0);
      chk("rst_dto", wb_dto[u], 16'h0);
      chk("rst_acks", {fs_ack[u], ab_ack[u]}, 2'b00);
      chk("rst_dti", {fs_dti[u], ab_dti[u]}, 32'h0);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    step();

    // round-robin, both ports kept pending for four transactions
    seed[1] = 16'h1234;
    issue(1, 0, 16'h0100, 1'b0, 16'h0);
    issue(1, 1, 16'h0200, 1'b0, 16'h0);
    issued = 2; n = 0;
    while (ordn[1] < 4 && n < 100) begin
      step();
      n++;
      for (int p = 0; p < 2; p++)
        if (!pend[1][p] && issued < 4) begin
          issue(1, p, 16'h0300 + 16'(issued), 1'b0, 16'h0);
          issued++;
        end
    end
    chk("rr_count", ordn[1], 4);
    for (int k = 0; k < 4; k++) chk("rr_order", ord[1][k], (k % 2 == 0) ? 1 : 0);

    // single fetch on a zero-wait bus
    seed[0] = 16'h7C01 ^ 16'h0010;
    issue(0, 0, 16'h0010, 1'b0, 16'h0);
    wait_idle(20);
    chk("fetch_lat", lat[0][0], 3);
    chk("fetch_dti", fs_dti[0], 16'h7C01);
    chk("fetch_adr", s_adr[0], 16'h0010);
    chk("fetch_we", s_we[0], 1'b0);

    // ack while idle must be ignored
    spur[0] = 1'b1;
    step();
    spur[0] = 1'b0;
    step(); step();
    chk("spur_acks", {fs_ack[0], ab_ack[0]}, {e_ack[0][0], e_ack[0][1]});
    chk("spur_cyc", wb_cyc[0], 1'b0);

    // simultaneous requests, fixed priority
    ordn[0] = 0;
    ps0 = pulses[0];
    issue(0, 0, 16'h0011, 1'b0, 16'h0);
    issue(0, 1, 16'h0020, 1'b0, 16'h0);
    wait_idle(40);
    chk("sim_pulses", pulses[0] - ps0, 2);
    chk("sim_first", ord[0][0], 1);
    chk("sim_second", ord[0][1], 0);

    // operand write
    prev = e_dti[0][1];
    issue(0, 1, 16'h8000, 1'b1, 16'hBEEF);
    wait_idle(20);
    chk("wr_we", s_we[0], 1'b1);
    chk("wr_dto", s_dto[0], 16'hBEEF);
    chk("wr_adr", s_adr[0], 16'h8000);
    chk("wr_dti_hold", ab_dti[0], prev);
    chk("wr_ack", ab_ack[0], e_ack[0][1]);

    // wait states, then reset mid-cycle
    waits[0] = 5;
    issue(0, 0, 16'h0044, 1'b0, 16'h0);
    step(); step(); step();
    chk("ws_cyc", wb_cyc[0], 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cyc", wb_cyc[0], 1'b0);
    chk("mid_rst_stb", wb_stb[0], 1'b0);
    chk("mid_rst_acks", {fs_ack[0], ab_ack[0]}, 2'b00);
    @(posedge clk);
    #2;
    rst_model();
    rst = 1'b1;
    #1;
    chk("post_rst_cyc", wb_cyc[0], 1'b0);
    wait_idle(40);
    chk("post_rst_dti", fs_dti[0], seed[0] ^ 16'h0044);
    chk("post_rst_ack", fs_ack[0], 1'b1);

    // randomized traffic on both instances
    for (int u = 0; u < 2; u++) begin
      wait_idle(100);
      seed[u] = 16'($urandom);
      for (int k = 0; k < 40; k++) begin
        waits[u] = $urandom_range(0, 2);
        for (int p = 0; p < 2; p++)
          if (!pend[u][p] && $urandom_range(0, 2) != 0)
            issue(u, p, 16'($urandom), (p != 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                  16'($urandom));
        repeat ($urandom_range(0, 3)) step();
      end
      wait_idle(100);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/dcpu16_arb.md
DCPU16_ARB -- requirements
Module: dcpu16_arb

Interface
REQ-001 SHALL have parameter AW, default 16, meaning word-address width of all address ports.
REQ-002 SHALL have parameter RR, default 0, meaning 0 = fixed priority (ab over fs) and 1 = round-robin.
REQ-003 SHALL have one clock and one reset: the clock and reset ports are named clk and rst, and reset is asynchronous and active-low.
REQ-004 SHALL have ports as follows (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-low reset
- fs_adr  in  AW  fetch word address
- fs_ena  in  1  fetch request toggle; a request is pending when fs_ena != fs_ack
- fs_ack  out  1  fetch completion toggle
- fs_dti  out  16  fetch read data
- ab_adr  in  AW  operand word address
- ab_dto  in  16  operand write data
- ab_wre  in  1  operand write enable
- ab_ena  in  1  operand request toggle
- ab_ack  out  1  operand completion toggle
- ab_dti  out  16  operand read data
- wb_cyc  out  1  bus cycle active
- wb_stb  out  1  bus strobe
- wb_we  out  1  bus write
- wb_adr  out  AW  bus address
- wb_dto  out  16  bus write data
- wb_dti  in  16  bus read data
- wb_ack  in  1  bus acknowledge

Function
REQ-005 SHALL detect a pending request per port as ena XOR ack, so that both ports stay compatible with the pipe-stall equation ena = (fs_ena ~^ fs_ack) & (ab_ena ~^ ab_ack).
REQ-006 SHALL implement the FSM states IDLE, FS, AB.
REQ-007 SHALL transition from IDLE when a request is pending: with RR=0 to AB if ab is pending, else to FS; with RR=1, when both are pending, to the port not granted last.
REQ-008 SHALL, on entering FS or AB, register wb_adr, wb_we and wb_dto from the granted port and assert wb_cyc=wb_stb=1 in the following cycle; wb_we SHALL be 0 for FS.
REQ-009 SHALL hold wb_adr, wb_we, wb_dto, wb_cyc and wb_stb stable in FS/AB until wb_ack is sampled high.
REQ-010 SHALL, on the cycle wb_ack is sampled high in state X, on the next edge: latch wb_dti into X_dti, toggle X_ack, deassert wb_cyc/wb_stb, and return to IDLE.
REQ-011 SHALL use minimum latency from request toggle to ack toggle of 3 clk with a zero-wait-state bus (1 cycle arbitrate, 1 cycle strobe, 1 cycle capture).
REQ-012 SHALL ignore wb_ack while in IDLE; such acks are spurious and leave no state change.
REQ-013 SHALL, for a write (ab_wre=1), leave ab_dti unchanged but still toggle ab_ack.
REQ-014 SHALL hold fs_dti and ab_dti until the next completion on that port.
REQ-015 SHALL serve simultaneous pending requests back-to-back, one bus cycle at a time, with at least one IDLE cycle between grants.
REQ-016 SHALL sample requester inputs only at grant; requester toggles during an active cycle are queued as pending, not lost.
REQ-017 SHALL keep the last-grant flag, used only when RR=1, updated at each completion.

Reset
REQ-018 SHALL, on rst low, asynchronously force: state IDLE; wb_cyc, wb_stb, wb_we = 0; wb_adr, wb_dto = 0; fs_ack, ab_ack = 0; fs_dti, ab_dti = 16'h0; last-grant = fs.
REQ-019 SHALL abandon any in-flight bus cycle when reset is asserted mid-cycle; wb_cyc drops immediately and no ack toggles.
REQ-020 SHALL leave a requester whose ena was already toggled with a pending request after reset release, which is then served normally.

Structure
REQ-021 SHALL define FSM state encodings (IDLE=2'd0, FS=2'd1, AB=2'd2) in a shared package dcpu16_pkg, alongside existing core constants.
REQ-022 SHALL be a single flat module with no sub-modules; the toggle-pending detect is inline.

Verification
REQ-023 SHALL pass the single fetch scenario: fs_adr=16'h0010, toggle fs_ena, wb_ack one cycle after stb with wb_dti=16'h7C01 -> wb_adr=16'h0010, wb_we=0, fs_ack toggles 3 clk after request, fs_dti=16'h7C01.
REQ-024 SHALL pass the simultaneous-request scenario (RR=0): toggle fs_ena and ab_ena in the same cycle -> AB granted first, then FS; two separate wb_cyc pulses; ab_ack toggles before fs_ack.
REQ-025 SHALL pass the round-robin scenario (RR=1): both ports held continuously pending for 4 transactions -> grant order alternates AB, FS, AB, FS after last-grant=fs reset value.
REQ-026 SHALL pass the write scenario: ab_adr=16'h8000, ab_dto=16'hBEEF, ab_wre=1 -> wb_we=1, wb_dto=16'hBEEF, ab_ack toggles, ab_dti stays at its prior value.
REQ-027 SHALL pass the wait-state and reset scenario: hold wb_ack low 5 cycles -> bus signals stable throughout; assert rst low on cycle 3 -> wb_cyc=0 asynchronously, acks remain 0, state IDLE after release.
REQ-028 SHALL pass the spurious-ack scenario: pulse wb_ack in IDLE -> no ack toggle and no data change.
